regfile_sequencer: RTL
======================

Name: regfile_sequencer

Overview:
- Bus master for the RegFile. It drives the RegFile read and write ports from the opposite side of the register-file interface.
- Two operations, chosen by `mode` on `start`:
  - INIT: fill all registers with a seeded pattern.
  - DUMP: read every register in pairs through both read ports and stream the words out over a valid/ready interface.
- Used for bring-up, self-check and debug readout of architectural state.

Parameters:
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.
- NREGS, 32: number of registers. Must be even and ≤ 2^ADDR_W.

Ports:
- clock  in  1  system clock; rising edge active.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- mode  in  1  0 = INIT, 1 = DUMP; sampled with start.
- seed  in  DATA_W  INIT base value; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- raA  out  ADDR_W  RegFile read address A.
- raB  out  ADDR_W  RegFile read address B.
- rdA  in  DATA_W  RegFile read data A; combinational from raA.
- rdB  in  DATA_W  RegFile read data B; combinational from raB.
- wa  out  ADDR_W  RegFile write address.
- wen  out  1  RegFile write enable.
- wd  out  DATA_W  RegFile write data.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  DATA_W  streamed register value.
- out_addr  out  ADDR_W  register index of out_data.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, immediate effect):
  - state returns to IDLE.
  - All outputs go to 0, including wen = 0 and out_valid = 0 with no glitch.
  - Counter and buffers are cleared.
  - A reset in the middle of an operation abandons it; no done pulse is produced.
- States: IDLE, INIT, DUMP_RD, DUMP_A, DUMP_B, DONE.
- IDLE:
  - On start = 1, latch mode and seed and clear counter k to 0.
  - mode = 0 → INIT with k = 1. mode = 1 → DUMP_RD with k = 0.
  - start in any other state is ignored.
- INIT:
  - Each cycle: wen = 1, wa = k, wd = (seed_latched + k) mod 2^DATA_W; then k increments.
  - After the write with k = NREGS−1, go to DONE.
  - R0 is never written: wen is never high with wa = 0.
  - Exactly NREGS−1 write cycles.
- DUMP_RD:
  - raA = k, raB = k+1.
  - At the end of the cycle, capture rdA → bufA and rdB → bufB, then go to DUMP_A.
- DUMP_A:
  - out_valid = 1, out_data = bufA, out_addr = k.
  - Transfer occurs on a clock edge with out_valid & out_ready; then go to DUMP_B.
- DUMP_B:
  - Same as DUMP_A with bufB and out_addr = k+1.
  - After the transfer: if k+2 = NREGS go to DONE, else k += 2 and go to DUMP_RD.
- Handshake rules:
  - out_valid is never withdrawn before a transfer.
  - out_data and out_addr are stable while out_valid & !out_ready.
  - out_ready asserted while out_valid = 0 has no effect.
- Timing:
  - Minimum 3 cycles per register pair, i.e. 3·NREGS/2 cycles per DUMP with out_ready held high.
  - raA, raB and wen are held at 0 in all states other than DUMP_RD and INIT respectively.
- DONE: done = 1 for exactly one cycle, busy still 1; then IDLE.
- Back-to-back operations: start may be asserted in the first IDLE cycle after DONE and is honoured.
- Arithmetic: seed + k wraps modulo 2^DATA_W; no overflow flag.

Test Plan:
- INIT, seed = 0x100:
  - start pulse → 31 consecutive cycles with wen = 1, wa = 1..31, wd = 0x101..0x11F.
  - wen never high with wa = 0.
  - done pulses once, 1 cycle after the last write; busy falls the cycle after done.
- DUMP after the above INIT, out_ready tied 1:
  - 32 transfers with out_addr = 0..31 and out_data = 0, 0x101..0x11F.
  - done follows 48 cycles after the start is accepted.
- Backpressure:
  - Drop out_ready for 5 cycles while out_addr = 3 is presented.
  - out_valid stays 1 and out_data = 0x103 is stable throughout.
  - No word is lost or duplicated; the full 32-word sequence completes.
- Seed wrap, INIT with seed = 0xFFFFFFF0:
  - R15 = 0xFFFFFFFF, R16 = 0x00000000, R31 = 0x0000000F.
  - A subsequent DUMP confirms these values.
- Reset mid-DUMP (at out_addr = 10) and mid-INIT (at wa = 7):
  - Outputs drop to 0 asynchronously, before the next clock edge.
  - No done pulse.
  - The next start runs the full operation from the beginning.
- start ignored while busy:
  - Pulse start with mode = 0 during a DUMP.
  - The DUMP completes unchanged and no write occurs.

Source files
------------

// File: rtl/regfile_sequencer.sv
// regfile_sequencer
//   Bus master for a register file, driving its read and write ports from the
//   opposite side of the register-file interface. Two operations, chosen by
//   `mode` when `start` is accepted in IDLE:
//     INIT (mode=0): writes R1..R(NREGS-1) with seed+k. R0 is never written.
//     DUMP (mode=1): reads registers in pairs through both read ports and
//                    streams them out over a valid/ready interface.
//   Every output is a flop, so an asynchronous reset forces all outputs to 0
//   at once.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   start, mode, seed      operation request; sampled only in IDLE
//   busy, done             high outside IDLE / one-cycle completion pulse
//   raA, raB, rdA, rdB     register-file read ports (rd* combinational from ra*)
//   wa, wen, wd            register-file write port
//   out_valid, out_ready   stream handshake
//   out_data, out_addr     streamed register value and its index
module regfile_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] raA,
    output logic [ADDR_W-1:0] raB,
    input  logic [DATA_W-1:0] rdA,
    input  logic [DATA_W-1:0] rdB,
    output logic [ADDR_W-1:0] wa,
    output logic              wen,
    output logic [DATA_W-1:0] wd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_DUMP_RD = 3'd2;
    localparam logic [2:0] S_DUMP_A  = 3'd3;
    localparam logic [2:0] S_DUMP_B  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [ADDR_W-1:0] K_ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] K_TWO       = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] K_LAST_INIT = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] K_LAST_PAIR = ADDR_W'(NREGS - 2);

    logic [2:0]        state, state_n;
    logic [ADDR_W-1:0] k, k_n;
    logic [DATA_W-1:0] seed_q, seed_n;
    logic [DATA_W-1:0] buf_a, buf_a_n;
    logic [DATA_W-1:0] buf_b, buf_b_n;

    logic              busy_n, done_n, wen_n, out_valid_n;
    logic [ADDR_W-1:0] raa_n, rab_n, wa_n, out_addr_n;
    logic [DATA_W-1:0] wd_n, out_data_n;

    // Next-state and counter logic.
    always_comb begin
        state_n = state;
        k_n     = k;
        seed_n  = seed_q;
        buf_a_n = buf_a;
        buf_b_n = buf_b;
        case (state)
            S_IDLE: begin
                if (start) begin
                    seed_n = seed;
                    if (mode) begin
                        state_n = S_DUMP_RD;
                        k_n     = '0;
                    end else begin
                        state_n = S_INIT;
                        k_n     = K_ONE;
                    end
                end
            end
            S_INIT: begin
                if (k == K_LAST_INIT) begin
                    state_n = S_DONE;
                end else begin
                    k_n = k + K_ONE;
                end
            end
            S_DUMP_RD: begin
                buf_a_n = rdA;
                buf_b_n = rdB;
                state_n = S_DUMP_A;
            end
            S_DUMP_A: begin
                if (out_ready) begin
                    state_n = S_DUMP_B;
                end
            end
            S_DUMP_B: begin
                if (out_ready) begin
                    if (k == K_LAST_PAIR) begin
                        state_n = S_DONE;
                    end else begin
                        k_n     = k + K_TWO;
                        state_n = S_DUMP_RD;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                k_n     = '0;
            end
            default: begin
                state_n = S_IDLE;
                k_n     = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered copies
    // line up with the state they belong to in the same cycle.
    always_comb begin
        busy_n      = (state_n != S_IDLE);
        done_n      = (state_n == S_DONE);
        wen_n       = (state_n == S_INIT);
        wa_n        = '0;
        wd_n        = '0;
        raa_n       = '0;
        rab_n       = '0;
        out_valid_n = 1'b0;
        out_data_n  = '0;
        out_addr_n  = '0;
        if (state_n == S_INIT) begin
            wa_n = k_n;
            wd_n = seed_n + DATA_W'(k_n);
        end
        if (state_n == S_DUMP_RD) begin
            raa_n = k_n;
            rab_n = k_n + K_ONE;
        end
        if (state_n == S_DUMP_A) begin
            out_valid_n = 1'b1;
            out_data_n  = buf_a_n;
            out_addr_n  = k_n;
        end
        if (state_n == S_DUMP_B) begin
            out_valid_n = 1'b1;
            out_data_n  = buf_b_n;
            out_addr_n  = k_n + K_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            k         <= '0;
            seed_q    <= '0;
            buf_a     <= '0;
            buf_b     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            raA       <= '0;
            raB       <= '0;
            wa        <= '0;
            wen       <= 1'b0;
            wd        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            seed_q    <= seed_n;
            buf_a     <= buf_a_n;
            buf_b     <= buf_b_n;
            busy      <= busy_n;
            done      <= done_n;
            raA       <= raa_n;
            raB       <= rab_n;
            wa        <= wa_n;
            wen       <= wen_n;
            wd        <= wd_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_addr  <= out_addr_n;
        end
    end

endmodule
